// File: rtl/led8_ctrl_if.sv
// Command channel for the LED ring sequencer.
// The host drives the opcode and operand under a valid/ready handshake.
interface led8_ctrl_if #(
  parameter int DIV_WIDTH = 24
) ();

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_op;
  logic [DIV_WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/led8_ctrl.sv
// 8-LED ring sequencer: rotate/bounce/step modes paced by a programmable
// rate divider, commanded over a valid/ready channel.
module led8_ctrl #(
  parameter int                   DIV_WIDTH   = 24,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(1000),
  parameter logic [7:0]           PAT_INIT    = 8'b0000_0001
) (
  input  logic        clock,
  input  logic        reset,
  led8_ctrl_if.slave  cmd,
  output logic [7:0]  diode,
  output logic        busy,
  output logic        step_pulse
);

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_LOAD      = 3'd1,
    OP_SET_DIV   = 3'd2,
    OP_RUN_LEFT  = 3'd3,
    OP_RUN_RIGHT = 3'd4,
    OP_BOUNCE    = 3'd5,
    OP_STOP      = 3'd6,
    OP_STEP      = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_STOPPED = 3'd0,
    ST_RUN_L   = 3'd1,
    ST_RUN_R   = 3'd2,
    ST_BNC_L   = 3'd3,
    ST_BNC_R   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           diode_q, diode_d;
  logic [DIV_WIDTH-1:0] div_q,   div_d;
  logic [DIV_WIDTH-1:0] cnt_q,   cnt_d;
  logic                 ready_q, ready_d;
  logic                 busy_q,  busy_d;
  logic                 pulse_q, pulse_d;

  logic                 accept;
  op_e                  op;
  logic                 running;
  logic [DIV_WIDTH-1:0] eff_div;
  logic                 tick;
  logic [7:0]           rot_l;
  logic [7:0]           rot_r;
  logic                 shift;

  assign accept  = cmd.cmd_valid & ready_q;
  assign op      = op_e'(cmd.cmd_op);
  assign running = (state_q != ST_STOPPED);

  // A zero divider would never match count-1, so it is paced like a divider of 1.
  assign eff_div = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
  assign tick    = running && (cnt_q == eff_div - DIV_WIDTH'(1));

  assign rot_l = {diode_q[6:0], diode_q[7]};
  assign rot_r = {diode_q[0], diode_q[7:1]};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    diode_d = diode_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    shift   = 1'b0;

    if (running) begin
      cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
    end

    if (accept) begin
      // An accepted command owns this edge; a coincident tick does not shift.
      if (op != OP_NOP) begin
        cnt_d = '0;
      end
      unique case (op)
        OP_LOAD:      diode_d = cmd.cmd_data[7:0];
        OP_SET_DIV:   div_d   = cmd.cmd_data;
        OP_RUN_LEFT:  state_d = ST_RUN_L;
        OP_RUN_RIGHT: state_d = ST_RUN_R;
        OP_BOUNCE:    state_d = ST_BNC_L;
        OP_STOP:      state_d = ST_STOPPED;
        OP_STEP: begin
          if (!running) begin
            diode_d = rot_l;
            shift   = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (tick) begin
      shift = 1'b1;
      unique case (state_q)
        ST_RUN_L: diode_d = rot_l;
        ST_RUN_R: diode_d = rot_r;
        ST_BNC_L: begin
          if (diode_q[7]) begin
            state_d = ST_BNC_R;
            diode_d = rot_r;
          end else begin
            diode_d = rot_l;
          end
        end
        ST_BNC_R: begin
          if (diode_q[0]) begin
            state_d = ST_BNC_L;
            diode_d = rot_l;
          end else begin
            diode_d = rot_r;
          end
        end
        default: shift = 1'b0;
      endcase
    end

    ready_d = ~accept;
    busy_d  = (state_d != ST_STOPPED);
    pulse_d = shift;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_STOPPED;
      diode_q <= PAT_INIT;
      div_q   <= DEFAULT_DIV;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      diode_q <= diode_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      pulse_q <= pulse_d;
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign diode         = diode_q;
  assign busy          = busy_q;
  assign step_pulse    = pulse_q;

  a_ready_gap : assert property (@(posedge clock) disable iff (reset)
    accept |=> !ready_q);

  a_busy_state : assert property (@(posedge clock) disable iff (reset)
    busy_q == (state_q != ST_STOPPED));

endmodule

// File: tb/tb_led8_ctrl.sv
// Directed bench for led8_ctrl: a vector table for the main modes plus
// hand-written sequences for handshake timing, tick collisions and reset.
module tb_led8_ctrl;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_LOAD      = 3'd1;
  localparam logic [2:0] OP_SET_DIV   = 3'd2;
  localparam logic [2:0] OP_RUN_LEFT  = 3'd3;
  localparam logic [2:0] OP_RUN_RIGHT = 3'd4;
  localparam logic [2:0] OP_BOUNCE    = 3'd5;
  localparam logic [2:0] OP_STOP      = 3'd6;
  localparam logic [2:0] OP_STEP      = 3'd7;

  typedef struct {
    bit          send;
    logic [2:0]  op;
    logic [23:0] data;
    int          wait_cyc;
    logic [7:0]  exp_diode;
    logic        exp_busy;
    logic        exp_pulse;
    string       name;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] diode;
  logic       busy;
  logic       step_pulse;

  int total  = 0;
  int passed = 0;

  vec_t vecs[$];

  led8_ctrl_if #(.DIV_WIDTH(24)) cmd_if ();

  led8_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .cmd        (cmd_if.slave),
    .diode      (diode),
    .busy       (busy),
    .step_pulse (step_pulse)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add_vec(input bit send, input logic [2:0] op, input logic [23:0] data,
                         input int wait_cyc, input logic [7:0] d, input logic b,
                         input logic p, input string name);
    vec_t v;
    v.send = send; v.op = op; v.data = data; v.wait_cyc = wait_cyc;
    v.exp_diode = d; v.exp_busy = b; v.exp_pulse = p; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for ready, presents one command for one cycle; returns
  // 1 time unit after the accept edge.
  task automatic send(input logic [2:0] op, input logic [23:0] data);
    int guard = 0;
    while (cmd_if.cmd_ready !== 1'b1 && guard < 20) begin
      cycles(1);
      guard++;
    end
    if (guard >= 20) check("ready_timeout", 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    cycles(1);
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    bit pulse_seen;

    reset            = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
    cmd_if.cmd_data  = '0;

    // Main flow: every entry optionally sends one command, then waits, then
    // checks diode/busy/step_pulse 1 time unit after the last edge.
    add_vec(1, OP_SET_DIV,   24'd3,    0, 8'h01, 0, 0, "setdiv3");
    add_vec(1, OP_RUN_LEFT,  24'd0,    0, 8'h01, 1, 0, "runl_accept");
    add_vec(0, OP_NOP,       24'd0,    2, 8'h01, 1, 0, "runl_pre_first");
    add_vec(0, OP_NOP,       24'd0,    1, 8'h02, 1, 1, "runl_first");
    add_vec(0, OP_NOP,       24'd0,    1, 8'h02, 1, 0, "runl_hold");
    add_vec(0, OP_NOP,       24'd0,    2, 8'h04, 1, 1, "runl_second");
    add_vec(0, OP_NOP,       24'd0,   15, 8'h80, 1, 1, "runl_msb");
    add_vec(0, OP_NOP,       24'd0,    3, 8'h01, 1, 1, "runl_wrap");
    add_vec(1, OP_STOP,      24'd0,    0, 8'h01, 0, 0, "stop1");
    add_vec(1, OP_SET_DIV,   24'd0,    0, 8'h01, 0, 0, "setdiv0");
    add_vec(1, OP_BOUNCE,    24'd0,    0, 8'h01, 1, 0, "bnc_accept");
    add_vec(0, OP_NOP,       24'd0,    1, 8'h02, 1, 1, "bnc_first");
    add_vec(0, OP_NOP,       24'd0,    6, 8'h80, 1, 1, "bnc_top");
    add_vec(0, OP_NOP,       24'd0,    1, 8'h40, 1, 1, "bnc_flip_r");
    add_vec(0, OP_NOP,       24'd0,    6, 8'h01, 1, 1, "bnc_bottom");
    add_vec(0, OP_NOP,       24'd0,    1, 8'h02, 1, 1, "bnc_flip_l");
    add_vec(1, OP_STOP,      24'd0,    0, 8'h02, 0, 0, "stop2");
    add_vec(1, OP_SET_DIV,   24'd2,    0, 8'h02, 0, 0, "setdiv2");
    add_vec(1, OP_LOAD,      24'hA5,   0, 8'hA5, 0, 0, "load_a5");
    add_vec(1, OP_RUN_RIGHT, 24'd0,    0, 8'hA5, 1, 0, "runr_accept");
    add_vec(0, OP_NOP,       24'd0,    2, 8'hD2, 1, 1, "runr_d2");
    add_vec(0, OP_NOP,       24'd0,    2, 8'h69, 1, 1, "runr_69");
    add_vec(0, OP_NOP,       24'd0,    2, 8'hB4, 1, 1, "runr_b4");
    add_vec(1, OP_STOP,      24'd0,    0, 8'hB4, 0, 0, "stop3");
    add_vec(0, OP_NOP,       24'd0,    5, 8'hB4, 0, 0, "stop_frozen");
    add_vec(1, OP_STEP,      24'd0,    0, 8'h69, 0, 1, "step");
    add_vec(0, OP_NOP,       24'd0,    1, 8'h69, 0, 0, "step_pulse_end");
    add_vec(1, OP_NOP,       24'd0,    0, 8'h69, 0, 0, "nop_stopped");

    cycles(3);
    reset = 1'b0;

    // Idle after reset: nothing moves, step_pulse stays low.
    pulse_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycles(1);
      if (step_pulse !== 1'b0) pulse_seen = 1'b1;
    end
    check("rst_diode", 32'(diode), 32'h01);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    check("rst_no_pulse", 32'(pulse_seen), 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].send) send(vecs[i].op, vecs[i].data);
      cycles(vecs[i].wait_cyc);
      check({vecs[i].name, ".diode"}, 32'(diode),      32'(vecs[i].exp_diode));
      check({vecs[i].name, ".busy"},  32'(busy),       32'(vecs[i].exp_busy));
      check({vecs[i].name, ".pulse"}, 32'(step_pulse), 32'(vecs[i].exp_pulse));
    end

    // Back-to-back: valid held high, second command waits out the ready gap.
    cycles(2);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_LOAD;
    cmd_if.cmd_data  = 24'h3C;
    cycles(1);
    check("b2b_first_diode", 32'(diode), 32'h3C);
    check("b2b_ready_low",   32'(cmd_if.cmd_ready), 32'd0);
    cmd_if.cmd_data  = 24'hC3;
    cycles(1);
    check("b2b_gap_diode",   32'(diode), 32'h3C);
    check("b2b_ready_back",  32'(cmd_if.cmd_ready), 32'd1);
    cycles(1);
    check("b2b_second_diode", 32'(diode), 32'hC3);
    check("b2b_ready_low2",  32'(cmd_if.cmd_ready), 32'd0);
    cmd_if.cmd_valid = 1'b0;

    // Command landing on a tick edge: no shift there, and the counter restarts.
    send(OP_SET_DIV, 24'd4);
    send(OP_RUN_LEFT, 24'd0);
    cycles(2);
    send(OP_SET_DIV, 24'd4);
    check("collide_diode", 32'(diode), 32'hC3);
    check("collide_pulse", 32'(step_pulse), 32'd0);
    cycles(3);
    check("collide_restart_hold", 32'(diode), 32'hC3);
    cycles(1);
    check("collide_restart_shift", 32'(diode), 32'h87);
    check("collide_restart_pulse", 32'(step_pulse), 32'd1);

    // Degenerate patterns in bounce mode.
    send(OP_SET_DIV, 24'd0);
    send(OP_LOAD, 24'hFF);
    send(OP_BOUNCE, 24'd0);
    cycles(3);
    check("bnc_ff_diode", 32'(diode), 32'hFF);
    check("bnc_ff_busy",  32'(busy), 32'd1);
    send(OP_LOAD, 24'h00);
    cycles(3);
    check("bnc_00_diode", 32'(diode), 32'h00);

    // Reset mid-divider while running at 0x10.
    send(OP_SET_DIV, 24'd4);
    send(OP_RUN_LEFT, 24'd0);
    send(OP_LOAD, 24'h10);
    cycles(1);
    check("pre_reset_diode", 32'(diode), 32'h10);
    #2 reset = 1'b1;
    #1;
    check("async_rst_diode", 32'(diode), 32'h01);
    check("async_rst_busy",  32'(busy), 32'd0);
    check("async_rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    check("async_rst_pulse", 32'(step_pulse), 32'd0);
    cycles(2);
    reset = 1'b0;
    send(OP_RUN_LEFT, 24'd0);
    cycles(999);
    check("default_div_hold", 32'(diode), 32'h01);
    cycles(1);
    check("default_div_shift", 32'(diode), 32'h02);
    check("default_div_pulse", 32'(step_pulse), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/led8_ctrl.md
Name: led8_ctrl

Overview:
Sequencer for the 8-LED ring. It owns the `diode` register and a programmable rate divider, and accepts commands over a valid/ready interface. Supported modes are rotate-left, rotate-right, bounce, stop and single-step, so the LED pattern can be driven at a visible rate from a slow host or test FSM.

Parameters:
- DIV_WIDTH, 24, width of the rate divider and of cmd_data.
- DEFAULT_DIV, 1000, divider value loaded at reset (clock cycles per shift).
- PAT_INIT, 8'b0000_0001, pattern loaded at reset.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  3  opcode: 0 NOP, 1 LOAD, 2 SET_DIV, 3 RUN_LEFT, 4 RUN_RIGHT, 5 BOUNCE, 6 STOP, 7 STEP.
- cmd_data  input  DIV_WIDTH  operand: LOAD uses [7:0]; SET_DIV uses all bits.
- diode  output  8  LED pattern, registered.
- busy  output  1  high in any run state.
- step_pulse  output  1  one-cycle pulse on every cycle in which diode shifts.

Behaviour:
- Reset (asynchronous, active-high):
  - diode = PAT_INIT, div_reg = DEFAULT_DIV, tick counter = 0.
  - state = STOPPED.
  - cmd_ready = 1, busy = 0, step_pulse = 0.
  - Reset asserted mid-run aborts immediately with no partial shift.
- Handshake:
  - A command is accepted on the rising edge where cmd_valid & cmd_ready.
  - cmd_ready drops for exactly the one cycle after an accept, then returns high. Maximum rate is one command per 2 cycles.
  - cmd_op and cmd_data are sampled only at the accept edge.
- Rotation definitions:
  - Left: diode[i] <= diode[i-1], diode[0] <= diode[7].
  - Right: diode[i] <= diode[i+1], diode[7] <= diode[0].
- Tick generator:
  - The counter runs only in run states.
  - tick = (counter == eff_div-1), then the counter returns to 0. eff_div = div_reg, except that div_reg = 0 is treated as 1 (tick every cycle).
  - The counter is cleared to 0 on every accepted command except NOP.
  - The first shift after RUN_*/BOUNCE occurs on the eff_div-th edge after the accept edge.
- States: STOPPED, RUN_L, RUN_R, BNC_L, BNC_R.
  - RUN_LEFT -> RUN_L; RUN_RIGHT -> RUN_R; BOUNCE -> BNC_L; STOP -> STOPPED. These transitions apply from any state.
  - RUN_L / RUN_R: rotate on every tick.
  - BNC_L on tick:
    - if diode[7] == 1: go to BNC_R and rotate right;
    - else rotate left.
  - BNC_R on tick:
    - if diode[0] == 1: go to BNC_L and rotate left;
    - else rotate right.
  - The direction reversal never stalls or repeats a pattern. From 0x01 the sequence is 01,02,…,80,40,…,01,02.
  - LOAD: diode <= cmd_data[7:0] at the accept edge; state unchanged.
  - SET_DIV: div_reg <= cmd_data; state unchanged.
  - STEP:
    - in STOPPED: one left rotate at the accept edge, with step_pulse asserted the following cycle;
    - in run states: accepted with no effect.
  - NOP: accepted with no effect; the counter is not cleared.
- Simultaneous events: an accept edge that coincides with a tick suppresses that tick's shift; the command takes priority.
- Degenerate patterns: 0x00 and 0xFF rotate unchanged. In bounce mode 0xFF flips direction every tick (the pattern never changes); 0x00 never flips.
- busy = (state != STOPPED), registered with the state.
- step_pulse is registered: high in the cycle after any edge at which diode shifted.

Test Plan:
- Reset, no commands, 50 cycles -> diode = 0x01, busy = 0, cmd_ready = 1, step_pulse never asserts.
- SET_DIV 3, then RUN_LEFT -> diode 02,04,08,… every 3 cycles with first shift 3 cycles after accept; after 0x80 comes 0x01; step_pulse appears once per shift.
- SET_DIV 0, BOUNCE -> diode changes every cycle: 01,02,…,80,40,…,01,02; busy = 1.
- LOAD 0xA5, RUN_RIGHT with div 2 -> 0xD2, 0x69, 0xB4; then STOP -> diode frozen, busy = 0 one cycle after accept; then STEP -> 0x69.
- Back-to-back cmd_valid held high with two commands -> second accepted 2 cycles after the first (cmd_ready low for one cycle); a command landing on a tick edge -> no shift on that edge.
- Assert reset while running mid-divider at pattern 0x10 -> diode = 0x01 asynchronously, state STOPPED, div_reg = DEFAULT_DIV; release reset and send RUN_LEFT -> first shift after 1000 cycles.
